// File: rtl/ifetch_buffer_if.sv
// Fetch-side bundle: iBus command/response channels plus the decode-facing instruction handshake.
// The master modport is the fetch buffer's view; slave is the bus/core environment's view.
interface ifetch_buffer_if;
  logic        iBus_cmd_valid;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_ready;
  logic        iBus_rsp_err;
  logic [31:0] iBus_rsp_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_err;

  modport master (
    output iBus_cmd_valid,
    output iBus_cmd_payload_pc,
    input  iBus_cmd_ready,
    input  iBus_rsp_ready,
    input  iBus_rsp_err,
    input  iBus_rsp_instr,
    output instr_valid,
    output instr_data,
    output instr_pc,
    output instr_err,
    input  instr_ready
  );

  modport slave (
    input  iBus_cmd_valid,
    input  iBus_cmd_payload_pc,
    output iBus_cmd_ready,
    output iBus_rsp_ready,
    output iBus_rsp_err,
    output iBus_rsp_instr,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    input  instr_err,
    output instr_ready
  );
endinterface

// File: rtl/ifetch_buffer.sv
// Instruction fetch front-end: sequential iBus word fetches with credit-limited issue,
// in-order response FIFO toward decode, and redirect handling that drops stale responses.
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rstf,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  ifetch_buffer_if.master      bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   rsp_pc, rsp_pc_nxt;
  logic [CW-1:0] outstanding, outstanding_nxt;
  logic [CW-1:0] drop_cnt, drop_cnt_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW-1:0] rd_ptr, rd_ptr_nxt;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic          mem_err   [DEPTH];

  logic [CW:0]   credit_used;
  logic          cmd_valid;
  logic          cmd_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic [31:0]   redirect_target;

  assign redirect_target = redirect_pc & ~32'h3;

  // Credits cover both in-flight and buffered words, so a kept response always finds a free slot.
  always_comb begin
    credit_used = {1'b0, outstanding} + {1'b0, count};
    cmd_valid   = rstf & ~redirect_valid & (credit_used < DEPTH_W);
    cmd_fire    = cmd_valid & bus.iBus_cmd_ready;
    // A response with nothing outstanding is a protocol violation and is ignored entirely.
    rsp_fire    = bus.iBus_rsp_ready & (outstanding != '0);
    head_valid  = rstf & (count != '0);
    push        = rsp_fire & (drop_cnt == '0) & ~redirect_valid;
    pop         = head_valid & bus.instr_ready & ~redirect_valid;
  end

  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    outstanding_nxt = outstanding + CW'(cmd_fire) - CW'(rsp_fire);
    drop_cnt_nxt    = drop_cnt;
    count_nxt       = count;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    if (redirect_valid) begin
      // No command can fire here, so outstanding_nxt already reflects only this cycle's response.
      fetch_pc_nxt = redirect_target;
      rsp_pc_nxt   = redirect_target;
      drop_cnt_nxt = outstanding_nxt;
      count_nxt    = '0;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
    end else begin
      if (cmd_fire)
        fetch_pc_nxt = fetch_pc + 32'd4;
      if (rsp_fire && drop_cnt != '0)
        drop_cnt_nxt = drop_cnt - CW'(1);
      if (push) begin
        rsp_pc_nxt = rsp_pc + 32'd4;
        wr_ptr_nxt = wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr_nxt = rd_ptr + AW'(1);
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstf) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop_cnt    <= drop_cnt_nxt;
      count       <= count_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
    end
  end

  // Storage needs no reset: outputs are qualified by count.
  always_ff @(posedge clk) begin
    if (rstf && push) begin
      mem_instr[wr_ptr] <= bus.iBus_rsp_instr;
      mem_pc[wr_ptr]    <= rsp_pc;
      mem_err[wr_ptr]   <= bus.iBus_rsp_err;
    end
  end

  always_comb begin
    bus.iBus_cmd_valid      = cmd_valid;
    bus.iBus_cmd_payload_pc = rstf ? fetch_pc : RESET_PC;
    bus.instr_valid         = head_valid;
    bus.instr_data          = '0;
    bus.instr_pc            = '0;
    bus.instr_err           = 1'b0;
    if (head_valid) begin
      bus.instr_data = mem_instr[rd_ptr];
      bus.instr_pc   = mem_pc[rd_ptr];
      bus.instr_err  = mem_err[rd_ptr];
    end
  end

endmodule
